spi_slave_resp: RTL

- SPI responder (slave) for the SoC's spi0 master pins (spi0_cs, spi0_clk, spi0_mosi, spi0_miso) on the fpioa mux.
- Provides a byte-stream endpoint so benches and FPGA companion logic can talk to SparrowRV firmware without a flash model.
- Oversamples the SPI pins in the system clock domain, runs SPI mode 0, MSB first, and exposes valid/ready byte interfaces on both sides.

---
 rtl/spi_slave_resp.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/spi_slave_resp.sv
// SPI mode-0 responder: oversamples cs/sck/mosi in the clk domain and moves frames over valid/ready.
// Latency: rx_valid rises one clk after the synchronized sck edge that completes a frame.
// Backpressure: tx_ready pulses only at a frame load; an unread rx frame makes the next frame drop and sets rx_ovf.
// Optional: define SPI_SLV_LSB_FIRST_EN to shift frames LSB first in both directions.
module spi_slave_resp #(
    parameter int DW       = 8,
    parameter int SYNC_STG = 2,
    parameter int TX_IDLE  = 8'hFF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          spi_cs_i,
    input  logic          spi_sck_i,
    input  logic          spi_mosi_i,
    output logic          spi_miso_o,
    output logic          spi_miso_oe,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic          rx_ovf,
    input  logic          ovf_clr,
    output logic          busy
);

    localparam int            CW       = $clog2(DW + 1);
    localparam logic [DW-1:0] IDLE_W   = DW'(TX_IDLE);
    localparam logic [CW-1:0] CNT_FULL = CW'(DW);
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t              state, state_n;
    logic [SYNC_STG-1:0] cs_sync, sck_sync, mosi_sync;
    logic                cs_s, sck_s, mosi_s, cs_prev, sck_prev;
    logic                cs_fall, cs_rise, sck_rise, sck_fall;
    logic [CW-1:0]       cnt;
    logic [DW-1:0]       tx_sr, tx_next, tx_shift;
    logic [DW-2:0]       rx_sr, rx_shift;
    logic [DW-1:0]       rx_word;
    logic                load_tx, frame_done;

    // Synchronize the asynchronous SPI pins and keep the previous value for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync   <= '1;
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_prev   <= 1'b1;
            sck_prev  <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STG-2:0], spi_cs_i};
            sck_sync  <= {sck_sync[SYNC_STG-2:0], spi_sck_i};
            mosi_sync <= {mosi_sync[SYNC_STG-2:0], spi_mosi_i};
            cs_prev   <= cs_s;
            sck_prev  <= sck_s;
        end
    end

    assign cs_s     = cs_sync[SYNC_STG-1];
    assign sck_s    = sck_sync[SYNC_STG-1];
    assign mosi_s   = mosi_sync[SYNC_STG-1];
    assign cs_fall  = cs_prev & ~cs_s;
    assign cs_rise  = ~cs_prev & cs_s;
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;

`ifdef SPI_SLV_LSB_FIRST_EN
    assign rx_word    = {mosi_s, rx_sr};
    assign rx_shift   = rx_word[DW-1:1];
    assign tx_shift   = {1'b0, tx_sr[DW-1:1]};
    assign spi_miso_o = tx_sr[0];
`else
    assign rx_word    = {rx_sr, mosi_s};
    assign rx_shift   = rx_word[DW-2:0];
    assign tx_shift   = {tx_sr[DW-2:0], 1'b0};
    assign spi_miso_o = tx_sr[DW-1];
`endif

    // Next-state logic; a TX load happens in LOAD and on the falling edge after a completed frame
    always_comb begin
        state_n = state;
        load_tx = 1'b0;
        case (state)
            IDLE:    if (cs_fall) state_n = LOAD;
            LOAD: begin
                load_tx = 1'b1;
                state_n = SHIFT;
            end
            SHIFT:   if (sck_fall && cnt == CNT_FULL) load_tx = 1'b1;
            default: state_n = IDLE;
        endcase
        // Deselect aborts everything, including a load in the same cycle
        if (cs_rise) begin
            state_n = IDLE;
            load_tx = 1'b0;
        end
    end

    assign tx_ready   = load_tx & tx_valid;
    assign tx_next    = tx_valid ? tx_data : IDLE_W;
    assign frame_done = (state == SHIFT) && sck_rise && !cs_rise && (cnt == CNT_LAST);

    // Frame engine: state, bit counter and both shift registers; MISO is the TX register's output bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            spi_miso_oe <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            spi_miso_oe <= (state_n != IDLE);
            busy        <= (state_n != IDLE);
            if (state_n == IDLE) begin
                cnt   <= '0;
                tx_sr <= '0;
            end else if (load_tx) begin
                tx_sr <= tx_next;
                cnt   <= '0;
            end else if (state == SHIFT) begin
                if (sck_rise && cnt != CNT_FULL) begin
                    rx_sr <= rx_shift;
                    cnt   <= cnt + CW'(1);
                end
                if (sck_fall) tx_sr <= tx_shift;
            end
        end
    end

    // Receive handshake and sticky overrun; an overrun set beats a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ovf   <= 1'b0;
        end else begin
            if (frame_done && (!rx_valid || rx_ready)) begin
                rx_data  <= rx_word;
                rx_valid <= 1'b1;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (frame_done && rx_valid && !rx_ready) rx_ovf <= 1'b1;
            else if (ovf_clr)                       rx_ovf <= 1'b0;
        end
    end

endmodule
